branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Dynamic branch predictor and EX-stage branch resolver for the 5-stage RV32I pipeline. Gives IF a same-cycle taken/target prediction from a direct-mapped BTB with 2-bit saturating counters. Checks each resolved branch or jump in EX against the prediction carried down the pipe, and drives `modify_pc_ex` / `redirect_pc` to the hazard unit and PC-update logic. It is the producer side of the `modify_pc_ex` control-hazard interface.

## Interface
- `ENTRIES`, default 16: BTB entries; power of two, ≥ 2.
- `IDX_W`, default 4: log2(`ENTRIES`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_pc`  in  32  fetch PC to predict.
- `if_pred_taken`  out  1  prediction for `if_pc`; combinational.
- `if_pred_target`  out  32  predicted target; equals `if_pc + 4` when not taken.
- `ex_valid`  in  1  EX holds a live, unflushed instruction.
- `ex_pc`  in  32  PC of EX instruction.
- `ex_is_branch`  in  1  EX opcode is BTYPE.
- `ex_is_jump`  in  1  EX opcode is JTYPE or IJALR.
- `ex_taken`  in  1  actual outcome; must be 1 when `ex_is_jump`.
- `ex_target`  in  32  actual target address.
- `ex_pred_taken`  in  1  `if_pred_taken` carried to EX with the instruction.
- `ex_pred_target`  in  32  `if_pred_target` carried to EX.
- `modify_pc_ex`  out  1  misprediction; IF must redirect and the hazard unit must flush.
- `redirect_pc`  out  32  corrected fetch PC.
- `branch_cnt`  out  32  count of resolved control instructions.
- `mispredict_cnt`  out  32  count of `modify_pc_ex` assertions.

## Operation
- BTB entry fields: `valid`, `tag` = `pc[31:IDX_W+2]`, `target[31:0]`, `ctr[1:0]`. Index = `pc[IDX_W+1:2]`.
- Lookup (combinational):
  - hit = `valid && tag match`.
  - `if_pred_taken = hit && ctr[1]`.
  - `if_pred_target = if_pred_taken ? target : if_pc + 4`, modulo 2^32.
- Resolve (combinational), with `ctl = ex_valid && (ex_is_branch || ex_is_jump)`:
  - ctl: `modify_pc_ex = (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target)`.
  - `ex_valid` with a non-control instruction and `ex_pred_taken = 1` (alias hit): `modify_pc_ex = 1`.
  - Otherwise 0.
  - `redirect_pc = (ctl && ex_taken) ? ex_target : ex_pc + 4`.
- Update, on the clock edge when `ctl`, at the `ex_pc` index:
  - Hit, branch: `ctr` increments if taken, decrements if not; saturates at 3 and 0. `target` is written when taken.
  - Hit, jump: `ctr <= 3`; `target <= ex_target`.
  - Miss, taken: allocate (overwrite) with `valid = 1`, new tag, `target = ex_target`. `ctr = 2` for a branch, 3 for a jump.
  - Miss, not taken: no write.
- Alias case (`ex_valid`, non-control, `ex_pred_taken = 1`): the matching entry, if its tag still hits, is invalidated (`valid <= 0`).
- Counters:
  - `branch_cnt` increments on each cycle with `ctl`.
  - `mispredict_cnt` increments on each cycle with `modify_pc_ex`.
  - Both saturate at 0xFFFFFFFF.
- `ex_valid = 0` blocks all updates and forces `modify_pc_ex = 0`.

## Timing
- Reset (async assert, sync deassert by the system): all `valid = 0`, `ctr = 2'b01`, `target = 0`, `tag = 0`, counters = 0. Outputs are then `if_pred_taken = 0`, `if_pred_target = if_pc + 4`, `modify_pc_ex = 0`, `redirect_pc = ex_pc + 4`.
- Lookup and resolve have 0-cycle latency, purely combinational from inputs and state.
- BTB updates become visible to lookup on the cycle after the update edge. A same-cycle lookup of the index being written returns the old contents; there is no bypass.
- `modify_pc_ex` asserts for exactly the cycles EX holds a mispredicted instruction. It is 1 cycle per instruction under a normal pipeline, because the hazard unit flushes ID/EX the next cycle.
- Reset mid-operation clears the BTB and counters immediately, regardless of the clock.
- Back-to-back updates to the same index on consecutive cycles each apply in order; counter saturation holds every cycle.

## Test plan
- Reset, then `if_pc = 0x100` → `if_pred_taken = 0`, `if_pred_target = 0x104`, counters 0.
- Branch at 0x100 resolves taken to 0x80 with pred 0 → `modify_pc_ex = 1`, `redirect_pc = 0x80`. Next cycle, `if_pc = 0x100` → pred taken, target 0x80, `mispredict_cnt = 1`.
- Same branch, ctr = 2, resolves not taken with pred 1 → `modify_pc_ex = 1`, `redirect_pc = 0x104`, ctr becomes 1. Lookup then predicts not taken.
- Resolve taken 4 times → ctr holds 3. Then 1 not-taken → ctr 2, still predicts taken.
- JALR at 0x200 with pred target 0x300, actual 0x340 → `modify_pc_ex = 1`, `redirect_pc = 0x340`. BTB target becomes 0x340.
- `ex_valid = 0` with mismatched prediction → `modify_pc_ex = 0`, no BTB or counter change.
- Alias: non-control at 0x100 with `ex_pred_taken = 1` → `modify_pc_ex = 1`, `redirect_pc = 0x104`, entry invalidated.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - IF lookup and EX resolve signal bundle for the branch predictor
interface branch_predict_unit_if;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        modify_pc_ex;
    logic [31:0] redirect_pc;

    // Pipeline side: supplies fetch PC and the resolved EX instruction.
    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target, modify_pc_ex, redirect_pc
    );

    // Predictor side.
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target, modify_pc_ex, redirect_pc
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB predictor with EX-stage branch resolution
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predict_unit_if.slave bp,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispredict_cnt
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [31:0]        btb_target [ENTRIES];
    logic [1:0]         btb_ctr    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             if_hit;
    logic             ex_hit;
    logic             ctl;
    logic             alias_inv;
    logic [1:0]       ctr_next;
    logic             unused_pc_bits;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[31:IDX_W+2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_tag = bp.ex_pc[31:IDX_W+2];

    // Instruction alignment bits never reach the BTB.
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // Same-cycle fetch prediction; reads registered state only, so no bypass of a write in flight.
    always_comb begin
        if_hit            = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
        bp.if_pred_taken  = if_hit && btb_ctr[if_idx][1];
        bp.if_pred_target = bp.if_pred_taken ? btb_target[if_idx] : bp.if_pc + 32'd4;
    end

    // EX-stage resolution: compare actual outcome with the prediction carried down the pipe.
    always_comb begin
        ctl       = bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump);
        ex_hit    = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        // A predicted-taken non-control instruction means IF followed a stale/aliased entry.
        alias_inv = bp.ex_valid && !ctl && bp.ex_pred_taken;
        bp.modify_pc_ex = 1'b0;
        if (ctl) begin
            bp.modify_pc_ex = (bp.ex_pred_taken != bp.ex_taken) ||
                              (bp.ex_taken && (bp.ex_pred_target != bp.ex_target));
        end else if (alias_inv) begin
            bp.modify_pc_ex = 1'b1;
        end
        bp.redirect_pc = (ctl && bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
    end

    // Saturating 2-bit counter step for a branch that hits.
    always_comb begin
        ctr_next = btb_ctr[ex_idx];
        if (bp.ex_taken) begin
            if (btb_ctr[ex_idx] != 2'b11) ctr_next = btb_ctr[ex_idx] + 2'b01;
        end else begin
            if (btb_ctr[ex_idx] != 2'b00) ctr_next = btb_ctr[ex_idx] - 2'b01;
        end
    end

    // BTB training on resolved control instructions and invalidation of aliased entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (ctl) begin
            if (ex_hit) begin
                if (bp.ex_is_jump) begin
                    btb_ctr[ex_idx]    <= 2'b11;
                    btb_target[ex_idx] <= bp.ex_target;
                end else begin
                    btb_ctr[ex_idx] <= ctr_next;
                    if (bp.ex_taken) btb_target[ex_idx] <= bp.ex_target;
                end
            end else if (bp.ex_taken) begin
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= bp.ex_target;
                btb_ctr[ex_idx]    <= bp.ex_is_jump ? 2'b11 : 2'b10;
            end
        end else if (alias_inv && ex_hit) begin
            btb_valid[ex_idx] <= 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (ctl && (branch_cnt != 32'hFFFF_FFFF))
                branch_cnt <= branch_cnt + 32'd1;
            if (bp.modify_pc_ex && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
    int          total = 0;
    int          bad = 0;

    branch_predict_unit_if bif ();

    branch_predict_unit #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bp             (bif),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ev;
        logic [31:0] pc;
        logic        br;
        logic        jp;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [31:0] ipc;
        logic        emod;
        logic [31:0] ered;
        logic        ept;
        logic [31:0] eptg;
    } step_t;

    typedef struct packed {
        logic        emod;
        logic [31:0] ered;
        logic        ept;
        logic [31:0] eptg;
    } exp_t;

    exp_t sb[$];

    function automatic step_t mk(logic ev, logic [31:0] pc, logic br, logic jp, logic tk,
                                 logic [31:0] tgt, logic ptk, logic [31:0] ptgt, logic [31:0] ipc,
                                 logic emod, logic [31:0] ered, logic ept, logic [31:0] eptg);
        step_t s;
        s = '{ev, pc, br, jp, tk, tgt, ptk, ptgt, ipc, emod, ered, ept, eptg};
        return s;
    endfunction

    function automatic step_t idle(logic [31:0] pc, logic ept, logic [31:0] eptg);
        return mk(1'b0, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc, 1'b0, pc + 32'd4, ept, eptg);
    endfunction

    // Drive one cycle of stimulus and record what the outputs must be.
    task automatic apply(input step_t s);
        exp_t e;
        bif.ex_valid       = s.ev;
        bif.ex_pc          = s.pc;
        bif.ex_is_branch   = s.br;
        bif.ex_is_jump     = s.jp;
        bif.ex_taken       = s.tk;
        bif.ex_target      = s.tgt;
        bif.ex_pred_taken  = s.ptk;
        bif.ex_pred_target = s.ptgt;
        bif.if_pc          = s.ipc;
        e = '{s.emod, s.ered, s.ept, s.eptg};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        apply(idle(32'h100, 1'b0, 32'h104));
        bif.ex_pc = 32'h500;
        sb[0].ered = 32'h504;
        #1 rst_n = 1'b0;
        #2;
        e = sb.pop_front();
        total++; if (bif.if_pred_taken !== e.ept) begin bad++; $display("FAIL reset pred_taken got=%0b exp=%0b", bif.if_pred_taken, e.ept); end
        total++; if (bif.if_pred_target !== e.eptg) begin bad++; $display("FAIL reset pred_target got=%h exp=%h", bif.if_pred_target, e.eptg); end
        total++; if (bif.modify_pc_ex !== e.emod) begin bad++; $display("FAIL reset modify got=%0b exp=%0b", bif.modify_pc_ex, e.emod); end
        total++; if (bif.redirect_pc !== e.ered) begin bad++; $display("FAIL reset redirect got=%h exp=%h", bif.redirect_pc, e.ered); end
        total++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin bad++; $display("FAIL reset counters got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run a stimulus table, compare every cycle, then check counters after the last table row.
    task automatic test_steps(input string name, input step_t st[$], input int exp_br, input int exp_mis);
        exp_t e;
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            #1;
            e = sb.pop_front();
            total++; if (bif.modify_pc_ex !== e.emod) begin bad++; $display("FAIL %s[%0d] modify got=%0b exp=%0b", name, i, bif.modify_pc_ex, e.emod); end
            total++; if (bif.redirect_pc !== e.ered) begin bad++; $display("FAIL %s[%0d] redirect got=%h exp=%h", name, i, bif.redirect_pc, e.ered); end
            total++; if (bif.if_pred_taken !== e.ept) begin bad++; $display("FAIL %s[%0d] pred_taken got=%0b exp=%0b", name, i, bif.if_pred_taken, e.ept); end
            total++; if (bif.if_pred_target !== e.eptg) begin bad++; $display("FAIL %s[%0d] pred_target got=%h exp=%h", name, i, bif.if_pred_target, e.eptg); end
        end
        total++; if (branch_cnt !== exp_br) begin bad++; $display("FAIL %s branch_cnt got=%0d exp=%0d", name, branch_cnt, exp_br); end
        total++; if (mispredict_cnt !== exp_mis) begin bad++; $display("FAIL %s mispredict_cnt got=%0d exp=%0d", name, mispredict_cnt, exp_mis); end
    endtask

    task automatic test_branch_learn();
        step_t st[$];
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 32'h100, 1, 32'h80, 0, 32'h104));
        st.push_back(idle(32'h100, 1'b1, 32'h80));
        test_steps("learn", st, 1, 1);
    endtask

    task automatic test_not_taken();
        step_t st[$];
        st.push_back(mk(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 32'h100, 1, 32'h104, 1, 32'h80));
        st.push_back(idle(32'h100, 1'b0, 32'h104));
        test_steps("not_taken", st, 2, 2);
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 32'h100, 1, 32'h80, 0, 32'h104));
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 32'h100, 0, 32'h80, 1, 32'h80));
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 32'h100, 0, 32'h80, 1, 32'h80));
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 32'h100, 0, 32'h80, 1, 32'h80));
        st.push_back(mk(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 32'h100, 1, 32'h104, 1, 32'h80));
        st.push_back(idle(32'h100, 1'b1, 32'h80));
        test_steps("saturate", st, 7, 4);
    endtask

    task automatic test_jalr();
        step_t st[$];
        st.push_back(mk(1, 32'h200, 0, 1, 1, 32'h300, 0, 32'h204, 32'h200, 1, 32'h300, 0, 32'h204));
        st.push_back(mk(1, 32'h200, 0, 1, 1, 32'h340, 1, 32'h300, 32'h200, 1, 32'h340, 1, 32'h300));
        st.push_back(idle(32'h200, 1'b1, 32'h340));
        test_steps("jalr", st, 9, 6);
    endtask

    task automatic test_ex_invalid();
        step_t st[$];
        st.push_back(mk(0, 32'h200, 1, 0, 1, 32'h900, 0, 32'h204, 32'h200, 0, 32'h204, 1, 32'h340));
        st.push_back(idle(32'h200, 1'b1, 32'h340));
        test_steps("ex_invalid", st, 9, 6);
    endtask

    task automatic test_alias();
        step_t st[$];
        st.push_back(mk(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104, 32'h100, 1, 32'h80, 0, 32'h104));
        st.push_back(mk(1, 32'h100, 0, 0, 0, 32'h0, 1, 32'h80, 32'h100, 1, 32'h104, 1, 32'h80));
        st.push_back(idle(32'h100, 1'b0, 32'h104));
        test_steps("alias", st, 10, 8);
    endtask

    task automatic test_reset_mid();
        step_t st[$];
        st.push_back(mk(1, 32'h104, 0, 1, 1, 32'h40, 0, 32'h108, 32'h104, 1, 32'h40, 0, 32'h108));
        st.push_back(idle(32'h104, 1'b1, 32'h40));
        test_steps("pre_reset", st, 11, 9);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bif.if_pred_taken !== 1'b0 || bif.if_pred_target !== 32'h108) begin bad++; $display("FAIL reset_mid lookup got=%0b/%h exp=0/00000108", bif.if_pred_taken, bif.if_pred_target); end
        total++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin bad++; $display("FAIL reset_mid counters got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_branch_learn();
        test_not_taken();
        test_back_to_back();
        test_jalr();
        test_ex_invalid();
        test_alias();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end
endmodule
